// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
//  Module   : sys_defs (package)
//  Purpose  : Shared bus definitions for the processor/memory interface:
//             command encodings, command enum, default memory depth and a
//             helper that advances a transaction tag.
//  Revision : 1.0  initial release
// ============================================================================
package sys_defs;

    localparam int MEM_WORDS = 16384;   // 32-bit words (64 KiB)

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2,
        CMD_RSVD  = 2'd3     // reserved, behaves as NONE
    } bus_cmd_t;

    // Tag 0 means "no transaction", so the sequence runs 1..15 and wraps to 1.
    function automatic logic [3:0] tag_inc(input logic [3:0] tag);
        return (tag == 4'd15) ? 4'd1 : tag + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem
//  Purpose  : Word-organised unified memory model for the pipelined
//             processor. Reads are combinational, writes commit on the
//             rising clock edge, and every accepted command is tagged.
//  Ports    : clk               - rising-edge clock
//             rst               - asynchronous active-high reset
//             proc2mem_addr     - byte address (bits [1:0] ignored)
//             proc2mem_data     - store data
//             proc2mem_command  - 0 NONE, 1 LOAD, 2 STORE, 3 as NONE
//             mem2proc_response - tag of command accepted this cycle, 0 = none
//             mem2proc_data     - combinational load data, 0 when not loading
//             mem2proc_tag      - tag completed at the last clock edge
//  Revision : 1.0  initial release
// ============================================================================
module unified_mem #(
    parameter int MEM_WORDS = sys_defs::MEM_WORDS,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [DATA_W-1:0] proc2mem_data,
    input  logic [1:0]        proc2mem_command,
    output logic [3:0]        mem2proc_response,
    output logic [DATA_W-1:0] mem2proc_data,
    output logic [3:0]        mem2proc_tag
);
    import sys_defs::*;

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Plain unpacked array so a hex image can be loaded into it directly.
    logic [DATA_W-1:0] unified_memory [0:MEM_WORDS-1];

    logic [3:0]        next_tag;
    bus_cmd_t          cmd;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic              accept;
    logic              unused_addr_bits;

    assign cmd      = bus_cmd_t'(proc2mem_command);
    assign word_idx = proc2mem_addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];

    // Full-width compare: high address bits must not alias into the array.
    assign in_range = ({2'b00, word_idx} < ADDR_W'(MEM_WORDS));

    assign is_load  = (cmd == CMD_LOAD);
    assign is_store = (cmd == CMD_STORE);
    assign accept   = (is_load || is_store) && in_range;

    // Byte offset within the word is irrelevant for whole-word accesses.
    assign unused_addr_bits = &{1'b0, proc2mem_addr[1:0]};

    // Response is valid even during reset; next_tag is held at 1 then.
    always_comb begin
        mem2proc_response = 4'd0;
        if (accept) begin
            mem2proc_response = next_tag;
        end
    end

    // Read sees the pre-edge contents: a store in the same cycle is not
    // forwarded (and a single port never carries both anyway).
    always_comb begin
        mem2proc_data = '0;
        if (is_load && in_range) begin
            mem2proc_data = unified_memory[mem_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_tag     <= 4'd1;
            mem2proc_tag <= 4'd0;
        end else begin
            mem2proc_tag <= mem2proc_response;
            if (accept) begin
                next_tag <= tag_inc(next_tag);
            end
        end
    end

    // Array is deliberately excluded from reset so preloaded images survive;
    // stores are simply blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && is_store && in_range) begin
            unified_memory[mem_idx] <= proc2mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem
//  Purpose  : Self-checking bench for unified_mem: directed vector table
//             plus hand-written tag-wrap and reset-mid-stream sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_unified_mem;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_RSVD  = 2'd3;

    logic        clk;
    logic        rst;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic [1:0]  proc2mem_command;
    logic [3:0]  mem2proc_response;
    logic [31:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [13];

    unified_mem #(
        .MEM_WORDS(16384),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .proc2mem_addr    (proc2mem_addr),
        .proc2mem_data    (proc2mem_data),
        .proc2mem_command (proc2mem_command),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data    (mem2proc_data),
        .mem2proc_tag     (mem2proc_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one command on the falling edge, check combinational outputs
    // before the rising edge, then check the completion echo after it.
    task automatic step(input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] resp,
                        input logic [31:0] rdata, input string name);
        @(negedge clk);
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = wdata;
        #1;
        chk({name, ".resp"}, {28'd0, mem2proc_response}, {28'd0, resp});
        chk({name, ".data"}, mem2proc_data, rdata);
        @(posedge clk);
        #1;
        chk({name, ".tag"}, {28'd0, mem2proc_tag}, {28'd0, resp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{C_LOAD,  32'h0000_0000, 32'h0,          4'd1, 32'h0050_0093};
        vecs[1]  = '{C_STORE, 32'h0000_0100, 32'hDEAD_BEEF,  4'd2, 32'h0};
        vecs[2]  = '{C_LOAD,  32'h0000_0100, 32'h0,          4'd3, 32'hDEAD_BEEF};
        vecs[3]  = '{C_LOAD,  32'h0000_0103, 32'h0,          4'd4, 32'hDEAD_BEEF};
        vecs[4]  = '{C_LOAD,  32'h0001_0000, 32'h0,          4'd0, 32'h0};
        vecs[5]  = '{C_STORE, 32'h0001_0000, 32'h1234_5678,  4'd0, 32'h0};
        vecs[6]  = '{C_RSVD,  32'h0000_0100, 32'h0,          4'd0, 32'h0};
        vecs[7]  = '{C_NONE,  32'h0000_0100, 32'h0,          4'd0, 32'h0};
        vecs[8]  = '{C_STORE, 32'h0000_FFFC, 32'hCAFE_F00D,  4'd5, 32'h0};
        vecs[9]  = '{C_LOAD,  32'h0000_FFFC, 32'h0,          4'd6, 32'hCAFE_F00D};
        vecs[10] = '{C_LOAD,  32'h0000_0000, 32'h0,          4'd7, 32'h0050_0093};
        vecs[11] = '{C_LOAD,  32'h8000_0100, 32'h0,          4'd0, 32'h0};
        vecs[12] = '{C_LOAD,  32'h0001_0100, 32'h0,          4'd0, 32'h0};

        // Power-on reset: tag cleared, response still live.
        rst              = 1'b1;
        proc2mem_command = C_LOAD;
        proc2mem_addr    = 32'h0;
        proc2mem_data    = 32'h0;
        #2;
        chk("por.tag", {28'd0, mem2proc_tag}, 32'd0);
        chk("por.resp", {28'd0, mem2proc_response}, 32'd1);
        @(negedge clk);
        proc2mem_command = C_NONE;
        rst = 1'b0;

        // Preload word 0, then show it survives a reset pulse.
        step(C_STORE, 32'h0, 32'h0050_0093, 4'd1, 32'h0, "preload");
        @(negedge clk);
        proc2mem_command = C_NONE;
        rst = 1'b1;
        #1;
        chk("pulse.tag", {28'd0, mem2proc_tag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].resp,
                 vecs[i].rdata, $sformatf("vec%0d", i));
        end

        // Tag wrap: 1..15 then 1, idle gives 0 and holds the counter.
        @(negedge clk);
        proc2mem_command = C_NONE;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(C_LOAD, 32'h0, 32'h0, (i < 15) ? 4'(i + 1) : 4'd1,
                 32'h0050_0093, $sformatf("wrap%0d", i));
        end
        step(C_NONE, 32'h0, 32'h0, 4'd0, 32'h0, "idle");
        step(C_LOAD, 32'h0, 32'h0, 4'd2, 32'h0050_0093, "after_idle");

        // Reset mid-stream: in-flight tag dropped, store during reset ignored.
        step(C_LOAD, 32'h100, 32'h0, 4'd3, 32'hDEAD_BEEF, "inflight");
        #2;
        chk("inflight.pre", {28'd0, mem2proc_tag}, 32'd3);
        rst              = 1'b1;
        proc2mem_command = C_STORE;
        proc2mem_addr    = 32'h100;
        proc2mem_data    = 32'h5555_5555;
        #1;
        chk("midrst.tag", {28'd0, mem2proc_tag}, 32'd0);
        chk("midrst.resp", {28'd0, mem2proc_response}, 32'd1);
        @(posedge clk);
        #1;
        chk("midrst.tag_hold", {28'd0, mem2proc_tag}, 32'd0);
        @(negedge clk);
        proc2mem_command = C_NONE;
        rst = 1'b0;
        step(C_LOAD, 32'h100, 32'h0, 4'd1, 32'hDEAD_BEEF, "post_rst_store_ignored");
        step(C_LOAD, 32'h0,   32'h0, 4'd2, 32'h0050_0093, "post_rst_preload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
